// File: rtl/simon_pkg.sv
// Shared types for the Simon memory game: FSM state encoding and mode LED patterns.
package simon_pkg;

  typedef enum logic [2:0] {
    ST_INPUT,
    ST_PLAYBACK,
    ST_REPEAT,
    ST_LOSE,
    ST_WIN
  } state_t;

  localparam logic [2:0] LEDS_INPUT    = 3'b001;
  localparam logic [2:0] LEDS_PLAYBACK = 3'b010;
  localparam logic [2:0] LEDS_REPEAT   = 3'b100;
  localparam logic [2:0] LEDS_LOSE     = 3'b111;
  localparam logic [2:0] LEDS_WIN      = 3'b011;

endpackage

// File: rtl/simon_if.sv
// Player/display bus of the Simon engine; the engine is the slave, the front panel the master.
interface simon_if #(
  parameter int W     = 4,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          pat_valid;
  logic [W-1:0]  pat_in;
  logic [W-1:0]  pat_out;
  logic          pat_out_valid;
  logic [2:0]    mode_leds;
  logic [CW-1:0] count;

  modport master (
    output pat_valid, pat_in,
    input  pat_out, pat_out_valid, mode_leds, count
  );

  modport slave (
    input  pat_valid, pat_in,
    output pat_out, pat_out_valid, mode_leds, count
  );

endinterface

// File: rtl/simon_pattern_mem.sv
// Pattern store: synchronous write, asynchronous read, deliberately not reset.
module simon_pattern_mem #(
  parameter int W     = 4,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/simon_engine.sv
// Simon game controller: records one symbol per round, plays the pattern back and
// checks the player's repeat, ending in a terminal LOSE or WIN replay loop.
//
//   state    | meaning
//   INPUT    | waiting for the setter's next one-hot symbol
//   PLAYBACK | showing mem[0..count-1], PLAY_TICKS cycles each
//   REPEAT   | player re-enters the pattern, TIMEOUT idle cycles per symbol
//   LOSE     | terminal, replays the pattern forever
//   WIN      | terminal, pattern reached DEPTH, replays forever
module simon_engine
  import simon_pkg::*;
#(
  parameter int W          = 4,
  parameter int DEPTH      = 16,
  parameter int PLAY_TICKS = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic     clk,
  input  logic     rst,
  simon_if.slave   bus
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TMAX = (PLAY_TICKS > TIMEOUT) ? PLAY_TICKS : TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] PLAY_LAST = TW'(PLAY_TICKS - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

  state_t        state;
  logic [2:0]    mode_leds;
  logic          show;
  logic [CW-1:0] count;
  logic [CW-1:0] index;
  logic [TW-1:0] timer;

  logic [W-1:0]  rd_data;
  logic [CW-1:0] last;
  logic          legal;
  logic          match;
  logic          we;

  assign last  = count - CW'(1);
  assign legal = $onehot(bus.pat_in);
  assign match = (bus.pat_in == rd_data);
  // rst gates the write so a same-cycle strobe cannot touch memory
  assign we    = !rst && (state == ST_INPUT) && bus.pat_valid && legal;

  simon_pattern_mem #(
    .W    (W),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk    (clk),
    .we     (we),
    .wr_addr(count[AW-1:0]),
    .wr_data(bus.pat_in),
    .rd_addr(index[AW-1:0]),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INPUT;
      mode_leds <= LEDS_INPUT;
      show      <= 1'b0;
      count     <= '0;
      index     <= '0;
      timer     <= '0;
    end else begin
      case (state)
        ST_INPUT: begin
          if (bus.pat_valid && legal) begin
            count     <= count + CW'(1);
            index     <= '0;
            timer     <= '0;
            state     <= ST_PLAYBACK;
            mode_leds <= LEDS_PLAYBACK;
            show      <= 1'b1;
          end
        end
        ST_PLAYBACK: begin
          if (timer == PLAY_LAST) begin
            timer <= '0;
            if (index == last) begin
              index     <= '0;
              state     <= ST_REPEAT;
              mode_leds <= LEDS_REPEAT;
              show      <= 1'b0;
            end else begin
              index <= index + CW'(1);
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_REPEAT: begin
          if (bus.pat_valid) begin
            timer <= '0;
            if (match) begin
              if (index == last) begin
                index <= '0;
                if (count == DEPTH_C) begin
                  state     <= ST_WIN;
                  mode_leds <= LEDS_WIN;
                  show      <= 1'b1;
                end else begin
                  state     <= ST_INPUT;
                  mode_leds <= LEDS_INPUT;
                end
              end else begin
                index <= index + CW'(1);
              end
            end else begin
              index     <= '0;
              state     <= ST_LOSE;
              mode_leds <= LEDS_LOSE;
              show      <= 1'b1;
            end
          end else if (timer == TO_LAST) begin
            timer     <= '0;
            index     <= '0;
            state     <= ST_LOSE;
            mode_leds <= LEDS_LOSE;
            show      <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_LOSE, ST_WIN: begin
          if (timer == PLAY_LAST) begin
            timer <= '0;
            index <= (index == last) ? '0 : index + CW'(1);
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state     <= ST_INPUT;
          mode_leds <= LEDS_INPUT;
          show      <= 1'b0;
          index     <= '0;
          timer     <= '0;
        end
      endcase
    end
  end

  assign bus.pat_out_valid = show;
  assign bus.pat_out       = show ? rd_data : '0;
  assign bus.mode_leds     = mode_leds;
  assign bus.count         = count;

endmodule

// File: doc/simon_engine.md
SIMON_ENGINE -- requirements
Module: simon_engine

Interface
REQ-001 Parameter W, default 4: pattern symbol width; one bit per button/LED colour.
REQ-002 Parameter DEPTH, default 16: maximum pattern length; reaching it wins the game.
REQ-003 Parameter PLAY_TICKS, default 8: clk cycles each symbol is shown during playback; minimum 1.
REQ-004 Parameter TIMEOUT, default 64: idle clk cycles allowed per symbol in REPEAT before a loss; minimum 1.
REQ-005 Local constant CW = $clog2(DEPTH+1).
REQ-006 clk  input  1  clock; all state changes on the rising edge.
REQ-007 rst  input  1  reset; synchronous, active-high.
REQ-008 pat_valid  input  1  one-cycle strobe; pat_in is sampled when it is high.
REQ-009 pat_in  input  W  player/setter symbol.
REQ-010 pat_out  output  W  symbol being displayed; 0 when pat_out_valid is low.
REQ-011 pat_out_valid  output  1  high while a stored symbol is displayed.
REQ-012 mode_leds  output  3  INPUT 001, PLAYBACK 010, REPEAT 100, LOSE 111, WIN 011.
REQ-013 count  output  CW  current pattern length (score).

Function
REQ-014 State machine states: INPUT, PLAYBACK, REPEAT, LOSE, WIN; mode_leds is decoded from state only (Moore).
REQ-015 Internal registers: index (CW bits), timer (wide enough for max(PLAY_TICKS, TIMEOUT)), pattern memory DEPTH x W.
REQ-016 pat_in is legal iff it is one-hot (exactly one bit set).
REQ-017 INPUT, pat_valid with legal pat_in: mem[count] <= pat_in, count <= count+1, index <= 0, timer <= 0, next state PLAYBACK.
REQ-018 INPUT, pat_valid with illegal pat_in, or pat_valid low: no register change; remain in INPUT.
REQ-019 PLAYBACK: pat_out = mem[index], pat_out_valid = 1; timer increments each cycle.
REQ-020 PLAYBACK step: when timer = PLAY_TICKS-1, timer <= 0 and index <= index+1; if index = count-1, instead index <= 0 and next state REPEAT.
REQ-021 PLAYBACK and REPEAT ignore pat_valid/pat_in except as stated in REQ-022 to REQ-024.
REQ-022 REPEAT, pat_valid with pat_in = mem[index]: timer <= 0; if index < count-1, index <= index+1; otherwise index <= 0 and next state is WIN if count = DEPTH, else INPUT.
REQ-023 REPEAT, pat_valid with pat_in != mem[index], legal or illegal: next state LOSE, index <= 0, timer <= 0.
REQ-024 REPEAT, pat_valid low: timer increments; at timer = TIMEOUT-1, next state LOSE, index <= 0, timer <= 0.
REQ-025 LOSE and WIN: replay mem[0..count-1] cyclically using the REQ-020 timing, wrapping index to 0 after count-1.
REQ-026 LOSE and WIN are terminal: exit only via rst; pat_valid is ignored.
REQ-027 pat_out_valid = 0 and pat_out = 0 in INPUT and REPEAT.
REQ-028 count never exceeds DEPTH; no memory write is possible at count = DEPTH because WIN is entered first.
REQ-029 Reaction latency: a qualifying pat_valid in cycle n changes state/mode_leds in cycle n+1.

Reset
REQ-030 rst has priority over every other input, including a pat_valid in the same cycle.
REQ-031 On rst: state INPUT, count 0, index 0, timer 0; outputs mode_leds 001, pat_out_valid 0, pat_out 0, count 0.
REQ-032 Memory contents are not cleared by rst; they are unreadable until rewritten because count = 0.
REQ-033 rst asserted mid-PLAYBACK, REPEAT, LOSE or WIN returns to INPUT on the next edge.

Structure
REQ-034 Shared package simon_pkg holds the state enum and the five mode_leds constants.
REQ-035 One sub-module, simon_pattern_mem: DEPTH x W, synchronous write, asynchronous read, no reset.
REQ-036 The FSM, counters, legality check and compare live in simon_engine.

Verification (W=4, DEPTH=4, PLAY_TICKS=2, TIMEOUT=5)
REQ-037 rst, then pat_in=0011 with pat_valid -> state stays INPUT, count=0, mode_leds=001.
REQ-038 Enter 0001 -> PLAYBACK for exactly 2 cycles showing 0001, then REPEAT; repeat 0001 -> INPUT, count=1.
REQ-039 Build pattern 0001,0010; in REPEAT enter 0001 then 0100 -> LOSE (111); replay shows 0001,0010 cyclically, 2 cycles each.
REQ-040 In REPEAT with no input for 5 cycles -> LOSE on the 5th idle cycle edge.
REQ-041 Complete 4 rounds correctly -> WIN (011), count=4; pat_valid is then ignored.
REQ-042 rst asserted together with pat_valid during REPEAT -> INPUT, count=0, no compare effect.
